imem_arbiter: RTL

- Sequences a single-port instruction memory (async read, sync write, word-indexed by address[31:2]) between two requesters.
- The fetch stage issues reads from PC.
- The program loader (debug/UART path) writes instruction words.
- Registers the fetched instruction and stalls fetch while the loader owns the port; a burst counter bounds fetch starvation.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_burst_limiter.sv | 36 +++
 rtl/imem_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_LOAD  = 1'b1
  } imem_state_e;

  localparam int          IMEM_DEPTH = 128;
  localparam int          WIDX_W     = 30;
  localparam logic [31:0] FILL_WORD  = 32'h0000_0000;

endpackage

// File: rtl/imem_burst_limiter.sv
// Saturating loader-burst counter and grant decision.
// Guarantees one fetch slot after MAX_BURST loader grants.
module imem_burst_limiter #(
  parameter int MAX_BURST = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load_req,
  input  logic i_fetch_req,
  output logic o_load_win,
  output logic o_fetch_win
);

  localparam int CW = 4;

  logic [CW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat = (r_cnt == CW'(MAX_BURST));

  assign o_load_win  = i_rst_n & i_load_req
                     & (~w_sat | ~i_fetch_req);
  assign o_fetch_win = i_rst_n & i_fetch_req
                     & ~o_load_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_load_req || o_fetch_win) begin
      r_cnt <= '0;
    end else if (o_load_win && !w_sat) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: fetch vs program loader.
// Define IMEM_ARB_PERF_EN to add StallCount/LoadCount outputs.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int MAX_BURST = 4
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        FetchReq,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        Stall,
  input  logic        LoadReq,
  input  logic [31:0] LoadAddr,
  input  logic [31:0] LoadData,
  output logic        LoadAck,
  output logic        LoadErr,
  output logic        FetchErr,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [31:0] MemWD,
  input  logic [31:0] MemRD
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] LoadCount
`endif
);

  logic [WIDX_W-1:0] w_fidx;
  logic [WIDX_W-1:0] w_lidx;
  logic              w_f_oob;
  logic              w_l_bad;
  logic              w_load_win;
  logic              w_fetch_win;
  logic              w_unused;
  imem_state_e       w_state;

  assign w_fidx   = PC[31:2];
  assign w_lidx   = LoadAddr[31:2];
  assign w_unused = ^PC[1:0];

  // full 30-bit index compare: no aliasing past DEPTH
  assign w_f_oob = ({2'b00, w_fidx} >= 32'(DEPTH));
  assign w_l_bad = (|LoadAddr[1:0])
                 | ({2'b00, w_lidx} >= 32'(DEPTH));

  imem_burst_limiter #(
    .MAX_BURST (MAX_BURST)
  ) u_lim (
    .i_clk       (CLK),
    .i_rst_n     (RESETn),
    .i_load_req  (LoadReq),
    .i_fetch_req (FetchReq),
    .o_load_win  (w_load_win),
    .o_fetch_win (w_fetch_win)
  );

  assign w_state = w_load_win ? ST_LOAD : ST_FETCH;

  assign MemAddr = (w_state == ST_LOAD) ? {2'b00, w_lidx}
                                        : {2'b00, w_fidx};
  assign MemWE   = w_load_win & ~w_l_bad;
  assign MemWD   = MemWE ? LoadData : FILL_WORD;
  assign LoadAck = w_load_win;
  assign LoadErr = w_load_win & w_l_bad;
  assign Stall   = FetchReq & ~w_fetch_win;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      Instr      <= FILL_WORD;
      InstrValid <= 1'b0;
      FetchErr   <= 1'b0;
    end else if (w_fetch_win) begin
      Instr      <= w_f_oob ? FILL_WORD : MemRD;
      InstrValid <= 1'b1;
      FetchErr   <= w_f_oob;
    end else begin
      InstrValid <= 1'b0;
      FetchErr   <= 1'b0;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      StallCount <= '0;
      LoadCount  <= '0;
    end else begin
      StallCount <= StallCount + {31'b0, Stall};
      LoadCount  <= LoadCount + {31'b0, MemWE};
    end
  end
`endif

endmodule
